// File: rtl/flash_chk.sv
// flash_chk -- checks that an 8-bit flasher bus alternates between a value and
// its exact bitwise complement on every enabled sample.
//
// A run of LOCK_N consecutive good complement transitions declares lock.
// While locked, good transitions are counted in tgl_cnt. Bad transitions seen
// while locked or in error are counted in err_cnt. Both counters saturate.
//
// Ports:
//   clk      system clock, rising-edge
//   rs       asynchronous active-high reset
//   en       sample enable; din is only looked at on edges where en=1
//   din      observed flasher pattern
//   clr      synchronous clear of err_cnt and tgl_cnt (FSM untouched)
//   lock     high while in LOCKED
//   err      high while in ERROR
//   err_cnt  saturating count of bad transitions in LOCKED/ERROR
//   tgl_cnt  saturating count of good transitions in LOCKED
module flash_chk #(
  parameter int unsigned LOCK_N = 4  // consecutive goods needed for lock, 1..15
) (
  input  logic        clk,
  input  logic        rs,
  input  logic        en,
  input  logic [7:0]  din,
  input  logic        clr,
  output logic        lock,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [15:0] tgl_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  // run never exceeds LOCK_N-1 (<= 14), so run+1 always fits in 4 bits.
  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  logic [1:0] state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [7:0] prev_q;
  logic       good;
  logic       inc_err;
  logic       inc_tgl;

  assign good = (din == ~prev_q);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    inc_err = 1'b0;
    inc_tgl = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          // The first sample has no predecessor, so it is never judged.
          state_d = ST_HUNT;
          run_d   = 4'd0;
        end
        ST_HUNT: begin
          if (good) begin
            if (run_q + 4'd1 == LOCK_V) begin
              state_d = ST_LOCKED;
              run_d   = 4'd0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (good) begin
            inc_tgl = 1'b1;
          end else begin
            state_d = ST_ERROR;
            inc_err = 1'b1;
          end
        end
        default: begin  // ST_ERROR
          if (good) begin
            // The recovering transition already counts as the first good one.
            if (LOCK_V == 4'd1) begin
              state_d = ST_LOCKED;
              run_d   = 4'd0;
            end else begin
              state_d = ST_HUNT;
              run_d   = 4'd1;
            end
          end else begin
            inc_err = 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state_q <= ST_IDLE;
      run_q   <= 4'd0;
      prev_q  <= 8'h00;
    end else if (en) begin
      state_q <= state_d;
      run_q   <= run_d;
      prev_q  <= din;
    end
  end

  // clr beats a simultaneous increment; counters stick at all-ones.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      err_cnt <= 8'h00;
      tgl_cnt <= 16'h0000;
    end else if (clr) begin
      err_cnt <= 8'h00;
      tgl_cnt <= 16'h0000;
    end else begin
      if (inc_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (inc_tgl && (tgl_cnt != 16'hFFFF)) tgl_cnt <= tgl_cnt + 16'd1;
    end
  end

  // Decoded from registered state only: no combinational path from din/en.
  assign lock = (state_q == ST_LOCKED);
  assign err  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_flash_chk.sv
// tb_flash_chk -- scoreboard bench for flash_chk.
// The driver applies one sample per cycle on the falling edge and pushes the
// outputs the behavioural model predicts after the next rising edge; the
// monitor pops and compares one rising edge later (#1 after it).
module tb_flash_chk;

  localparam int LOCK_N = 4;

  logic        clk = 1'b0;
  logic        rs  = 1'b1;
  logic        en  = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        clr = 1'b0;
  logic        lock;
  logic        err;
  logic [7:0]  err_cnt;
  logic [15:0] tgl_cnt;

  flash_chk #(.LOCK_N(LOCK_N)) dut (
    .clk(clk), .rs(rs), .en(en), .din(din), .clr(clr),
    .lock(lock), .err(err), .err_cnt(err_cnt), .tgl_cnt(tgl_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lock;
    logic        err;
    int          err_cnt;
    int          tgl_cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural view: where the checker is, how long the current good streak
  // is, the last accepted sample, and the two tallies as plain integers.
  typedef enum {M_IDLE, M_HUNT, M_LOCKED, M_ERROR} mode_t;
  mode_t      m_mode;
  int         m_streak;
  logic [7:0] m_prev;
  int         m_errs;
  int         m_tgls;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode   = M_IDLE;
    m_streak = 0;
    m_prev   = 8'h00;
    m_errs   = 0;
    m_tgls   = 0;
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    e.lock    = (m_mode == M_LOCKED);
    e.err     = (m_mode == M_ERROR);
    e.err_cnt = m_errs;
    e.tgl_cnt = m_tgls;
    return e;
  endfunction

  function automatic void model_step(input logic e_in, input logic [7:0] d, input logic c);
    bit is_good;
    bit bump_err = 0;
    bit bump_tgl = 0;
    if (e_in) begin
      is_good = ((d ^ m_prev) == 8'hFF);
      case (m_mode)
        M_IDLE: begin m_mode = M_HUNT; m_streak = 0; end
        M_HUNT: begin
          m_streak = is_good ? m_streak + 1 : 0;
          if (m_streak == LOCK_N) begin m_mode = M_LOCKED; m_streak = 0; end
        end
        M_LOCKED: begin
          if (is_good) bump_tgl = 1;
          else begin m_mode = M_ERROR; bump_err = 1; end
        end
        M_ERROR: begin
          if (!is_good) bump_err = 1;
          else if (LOCK_N == 1) begin m_mode = M_LOCKED; m_streak = 0; end
          else begin m_mode = M_HUNT; m_streak = 1; end
        end
      endcase
      m_prev = d;
    end
    if (c) begin
      m_errs = 0;
      m_tgls = 0;
    end else begin
      if (bump_err) m_errs = (m_errs >= 255) ? 255 : m_errs + 1;
      if (bump_tgl) m_tgls = (m_tgls >= 65535) ? 65535 : m_tgls + 1;
    end
  endfunction

  task automatic drive(input logic e_in, input logic [7:0] d, input logic c = 1'b0);
    @(negedge clk);
    en  = e_in;
    din = d;
    clr = c;
    model_step(e_in, d, c);
    sb_q.push_back(model_now());
  endtask

  task automatic drive_seq(input logic [7:0] vals[$]);
    foreach (vals[i]) drive(1'b1, vals[i]);
  endtask

  // Synchronous-looking reset pulse; also checks the reset state.
  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    clr = 1'b0;
    rs  = 1'b1;
    #1;
    check("rst_lock", lock, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_tgl_cnt", tgl_cnt, 0);
    @(negedge clk);
    rs = 1'b0;
    model_reset();
  endtask

  // Monitor: pops one expectation per edge whenever one is outstanding.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_lock", lock, e.lock);
        check("sb_err", err, e.err);
        check("sb_err_cnt", err_cnt, e.err_cnt);
        check("sb_tgl_cnt", tgl_cnt, e.tgl_cnt);
      end
    end
  end

  initial begin
    logic [7:0] r;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Basic lock, then one toggle while locked.
    drive_seq('{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00});
    drive_seq('{8'hFF});
    // Good, then repeat -> ERROR; recovery and relock; one more toggle.
    drive_seq('{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF});

    // Asynchronous reset between edges while locked with nonzero counters.
    @(posedge clk);
    #3;
    check("pre_async_lock", lock, 1);
    rs = 1'b1;
    #1;
    check("async_lock", lock, 0);
    check("async_err", err, 0);
    check("async_err_cnt", err_cnt, 0);
    check("async_tgl_cnt", tgl_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rs = 1'b0;
    model_reset();
    drive_seq('{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF});

    // Broken streak while hunting; other complement pairs.
    do_reset();
    drive_seq('{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00});
    drive_seq('{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h3C});

    // Disabled samples are ignored, including by clr-free counters.
    do_reset();
    drive(1'b1, 8'h00);
    repeat (3) drive(1'b0, 8'($urandom));
    drive_seq('{8'hFF, 8'h00, 8'hFF, 8'h00});

    // Saturate err_cnt in ERROR, then clear on a bad sample.
    do_reset();
    drive_seq('{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00});
    repeat (300) drive(1'b1, 8'h00);
    drive(1'b1, 8'h00, 1'b1);
    drive(1'b1, 8'h00);

    // Random traffic biased toward complements so all states are visited.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 65) r = ~m_prev;
      else if ($urandom_range(1) == 0) r = m_prev;
      else r = 8'($urandom);
      drive($urandom_range(99) < 85, r, $urandom_range(99) < 2);
      if ($urandom_range(999) == 0) do_reset();
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so a wedged run still terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
